// File: rtl/kamus_pkg.sv
// Shared RV32I decode types: opcodes, ALU/memory encodings and the packed control word.
package kamus_pkg;

    localparam int REG_AW = 5;
    localparam int CTRL_W = 15;

    typedef logic [6:0] opcode_e;
    localparam opcode_e OPC_LUI    = 7'b0110111;
    localparam opcode_e OPC_AUIPC  = 7'b0010111;
    localparam opcode_e OPC_JAL    = 7'b1101111;
    localparam opcode_e OPC_JALR   = 7'b1100111;
    localparam opcode_e OPC_BRANCH = 7'b1100011;
    localparam opcode_e OPC_LOAD   = 7'b0000011;
    localparam opcode_e OPC_STORE  = 7'b0100011;
    localparam opcode_e OPC_OP_IMM = 7'b0010011;
    localparam opcode_e OPC_OP     = 7'b0110011;

    // Branch compares live in alu_op so execute needs no funct3; BLT/BLTU reuse SLT/SLTU.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_EQ     = 4'd11,
        ALU_NE     = 4'd12,
        ALU_GE     = 4'd13,
        ALU_GEU    = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        alu_op_e   alu_op;
        logic      src_a_pc;
        logic      src_b_imm;
        logic      reg_wr_en;
        logic      mem_rd;
        logic      mem_wr;
        mem_size_e mem_size;
        logic      mem_unsigned;
        logic      branch;
        logic      jump;
        logic      jalr;
    } ctrl_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word to control word, immediate and operand usage.
// Illegal encodings return an all-zero control word, zero immediate and no source usage.
module instr_decoder
    import kamus_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [31:0] imm,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    ctrl_t       c;
    logic [31:0] im;
    logic        r1, r2, bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = sext12(instr[31:20]);
    assign imm_s = sext12({instr[31:25], instr[11:7]});
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        c   = '0;
        im  = '0;
        r1  = 1'b0;
        r2  = 1'b0;
        bad = 1'b0;
        case (opcode)
            OPC_LUI: begin
                c.alu_op    = ALU_PASS_B;
                c.src_b_imm = 1'b1;
                c.reg_wr_en = 1'b1;
                im          = imm_u;
            end
            OPC_AUIPC: begin
                c.alu_op    = ALU_ADD;
                c.src_a_pc  = 1'b1;
                c.src_b_imm = 1'b1;
                c.reg_wr_en = 1'b1;
                im          = imm_u;
            end
            OPC_JAL: begin
                c.alu_op    = ALU_ADD;
                c.src_a_pc  = 1'b1;
                c.src_b_imm = 1'b1;
                c.reg_wr_en = 1'b1;
                c.jump      = 1'b1;
                im          = imm_j;
            end
            OPC_JALR: begin
                r1          = 1'b1;
                c.alu_op    = ALU_ADD;
                c.src_b_imm = 1'b1;
                c.reg_wr_en = 1'b1;
                c.jump      = 1'b1;
                c.jalr      = 1'b1;
                im          = imm_i;
                bad         = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                r1       = 1'b1;
                r2       = 1'b1;
                c.branch = 1'b1;
                im       = imm_b;
                case (funct3)
                    3'b000:  c.alu_op = ALU_EQ;
                    3'b001:  c.alu_op = ALU_NE;
                    3'b100:  c.alu_op = ALU_SLT;
                    3'b101:  c.alu_op = ALU_GE;
                    3'b110:  c.alu_op = ALU_SLTU;
                    3'b111:  c.alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                r1             = 1'b1;
                c.alu_op       = ALU_ADD;
                c.src_b_imm    = 1'b1;
                c.reg_wr_en    = 1'b1;
                c.mem_rd       = 1'b1;
                c.mem_size     = mem_size_e'(funct3[1:0]);
                c.mem_unsigned = funct3[2];
                im             = imm_i;
                bad            = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                r1          = 1'b1;
                r2          = 1'b1;
                c.alu_op    = ALU_ADD;
                c.src_b_imm = 1'b1;
                c.mem_wr    = 1'b1;
                c.mem_size  = mem_size_e'(funct3[1:0]);
                im          = imm_s;
                bad         = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OPC_OP_IMM: begin
                r1          = 1'b1;
                c.src_b_imm = 1'b1;
                c.reg_wr_en = 1'b1;
                im          = imm_i;
                case (funct3)
                    3'b000: c.alu_op = ALU_ADD;
                    3'b010: c.alu_op = ALU_SLT;
                    3'b011: c.alu_op = ALU_SLTU;
                    3'b100: c.alu_op = ALU_XOR;
                    3'b110: c.alu_op = ALU_OR;
                    3'b111: c.alu_op = ALU_AND;
                    3'b001: begin
                        c.alu_op = ALU_SLL;
                        bad      = (funct7 != 7'b0000000);
                    end
                    default: begin
                        c.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                        bad      = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                r1          = 1'b1;
                r2          = 1'b1;
                c.reg_wr_en = 1'b1;
                case (funct3)
                    3'b000:  c.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  c.alu_op = ALU_SLL;
                    3'b010:  c.alu_op = ALU_SLT;
                    3'b011:  c.alu_op = ALU_SLTU;
                    3'b100:  c.alu_op = ALU_XOR;
                    3'b101:  c.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  c.alu_op = ALU_OR;
                    default: c.alu_op = ALU_AND;
                endcase
                bad = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default: bad = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            c  = '0;
            im = '0;
            r1 = 1'b0;
            r2 = 1'b0;
        end
    end

    assign ctrl     = c;
    assign imm      = im;
    assign rs1_used = r1;
    assign rs2_used = r2;
    assign illegal  = bad;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-cycle registered decode aligned with synchronous register-file reads.
// Stalls fetch on downstream backpressure, flush, or a RAW/WAW hit in the busy scoreboard.
module decode_stage
    import kamus_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [XLEN-1:0]   if_instr_i,
    input  logic [XLEN-1:0]   if_pc_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic              wb_valid_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [XLEN-1:0]   id_pc_o,
    output logic [REG_AW-1:0] id_rd_addr_o,
    output logic [XLEN-1:0]   id_imm_o,
    output logic [CTRL_W-1:0] id_ctrl_o,
    output logic              id_illegal_o
);

    ctrl_t             dec_ctrl;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_rs1_used, dec_rs2_used, dec_illegal;

    logic [REG_AW-1:0] if_rs1, if_rs2, if_rd;
    logic              hazard, accept;

    logic              valid_q, illegal_q;
    logic [XLEN-1:0]   pc_q, imm_q;
    logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
    ctrl_t             ctrl_q;
    logic [NREGS-1:0]  busy_q, busy_d;

    instr_decoder u_dec (
        .instr    (if_instr_i),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used),
        .illegal  (dec_illegal)
    );

    assign if_rs1 = if_instr_i[19:15];
    assign if_rs2 = if_instr_i[24:20];
    assign if_rd  = if_instr_i[11:7];

    assign hazard = (dec_rs1_used && busy_q[if_rs1]) ||
                    (dec_rs2_used && busy_q[if_rs2]) ||
                    (dec_ctrl.reg_wr_en && busy_q[if_rd]);

    assign if_ready_o = (!valid_q || id_ready_i) && !hazard && !flush_i;
    assign accept     = if_valid_i && if_ready_o;

    // Outside the accept cycle the file keeps reading the held sources so its data stays put under stall.
    assign rs1_addr_o = accept ? if_rs1 : rs1_q;
    assign rs2_addr_o = accept ? if_rs2 : rs2_q;

    // Set is applied last so it wins over a same-edge writeback clear.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i && (wb_rd_addr_i != '0)) begin
            busy_d[wb_rd_addr_i] = 1'b0;
        end
        if (flush_i && valid_q && ctrl_q.reg_wr_en && (rd_q != '0)) begin
            busy_d[rd_q] = 1'b0;
        end
        if (accept && dec_ctrl.reg_wr_en && (if_rd != '0)) begin
            busy_d[if_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            pc_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            ctrl_q    <= '0;
            busy_q    <= '0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                valid_q   <= 1'b1;
                illegal_q <= dec_illegal;
                pc_q      <= if_pc_i;
                imm_q     <= dec_imm;
                rd_q      <= if_rd;
                rs1_q     <= if_rs1;
                rs2_q     <= if_rs2;
                ctrl_q    <= dec_ctrl;
            end else if (flush_i || id_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign id_valid_o   = valid_q;
    assign id_pc_o      = pc_q;
    assign id_rd_addr_o = rd_q;
    assign id_imm_o     = imm_q;
    assign id_ctrl_o    = ctrl_q;
    assign id_illegal_o = illegal_q;

endmodule
